// File: rtl/awg_pkg.sv
// Shared definitions for the AWG sequencer: wave codes, table entry layout, FSM encoding.
package awg_pkg;

  localparam logic [2:0] WAVE_SAW   = 3'd0;
  localparam logic [2:0] WAVE_TRI   = 3'd1;
  localparam logic [2:0] WAVE_SQR   = 3'd2;
  localparam logic [2:0] WAVE_SIN   = 3'd3;
  localparam logic [2:0] WAVE_NOISE = 3'd4;
  localparam logic [2:0] WAVE_OFF   = 3'd7;

  localparam int WAVE_W   = 3;
  localparam int FREQ_W   = 12;
  localparam int AMP_W    = 3;
  localparam int PHASE_W  = 8;
  localparam int FIELDS_W = WAVE_W + FREQ_W + AMP_W + PHASE_W;

  // Offsets of the config fields above the dwell field, which occupies the LSBs.
  localparam int PHASE_OFS = 0;
  localparam int AMP_OFS   = PHASE_OFS + PHASE_W;
  localparam int FREQ_OFS  = AMP_OFS + AMP_W;
  localparam int WAVE_OFS  = FREQ_OFS + FREQ_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/seq_table.sv
// Sequence table: register file with one synchronous write port and one combinational read port.
module seq_table
  import awg_pkg::*;
#(
  parameter int IDX_W   = 3,
  parameter int DWELL_W = 16
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [IDX_W-1:0]            wr_addr,
  input  logic [FIELDS_W+DWELL_W-1:0] wr_data,
  input  logic [IDX_W-1:0]            rd_addr,
  output logic [FIELDS_W+DWELL_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [FIELDS_W+DWELL_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; a same-cycle read returns the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/awg_seq_ctrl.sv
// Table-driven sequencer for the signal generator: plays entries with per-entry dwell in ticks.
module awg_seq_ctrl
  import awg_pkg::*;
#(
  parameter int IDX_W   = 3,
  parameter int DWELL_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        loop,
  input  logic [IDX_W-1:0]            last_idx,
  input  logic                        wr_en,
  input  logic [IDX_W-1:0]            wr_addr,
  input  logic [FIELDS_W+DWELL_W-1:0] wr_data,
  output logic [WAVE_W-1:0]           state,
  output logic [FREQ_W-1:0]           state_freq,
  output logic [AMP_W-1:0]            state_amp,
  output logic [PHASE_W-1:0]          state_phase,
  output logic [IDX_W-1:0]            cur_idx,
  output logic                        busy,
  output logic                        done
);

  seq_state_e                  fsm_st;
  logic [DWELL_W-1:0]          dwell_cnt;
  logic [IDX_W-1:0]            rd_addr;
  logic [FIELDS_W+DWELL_W-1:0] rd_data;
  logic [DWELL_W-1:0]          rd_dwell;
  logic [DWELL_W-1:0]          ld_dwell;
  logic                        end_of_list;
  logic                        end_of_entry;

  seq_table #(.IDX_W(IDX_W), .DWELL_W(DWELL_W)) u_table (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // The list also ends at the table top, so a last_idx lowered below cur_idx cannot run away.
  assign end_of_list  = (cur_idx == last_idx) || (cur_idx == {IDX_W{1'b1}});
  assign end_of_entry = (dwell_cnt <= DWELL_W'(1));
  assign rd_addr      = (fsm_st == ST_IDLE || end_of_list) ? '0 : cur_idx + IDX_W'(1);
  assign rd_dwell     = rd_data[DWELL_W-1:0];
  assign ld_dwell     = (rd_dwell == '0) ? DWELL_W'(1) : rd_dwell;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_st      <= ST_IDLE;
      dwell_cnt   <= '0;
      cur_idx     <= '0;
      state       <= WAVE_OFF;
      state_freq  <= '0;
      state_amp   <= '0;
      state_phase <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm_st)
        ST_IDLE: begin
          if (start && !stop) begin
            fsm_st      <= ST_RUN;
            busy        <= 1'b1;
            cur_idx     <= '0;
            dwell_cnt   <= ld_dwell;
            state       <= rd_data[DWELL_W+WAVE_OFS  +: WAVE_W];
            state_freq  <= rd_data[DWELL_W+FREQ_OFS  +: FREQ_W];
            state_amp   <= rd_data[DWELL_W+AMP_OFS   +: AMP_W];
            state_phase <= rd_data[DWELL_W+PHASE_OFS +: PHASE_W];
          end
        end
        ST_RUN: begin
          if (stop || (tick && end_of_entry && end_of_list && !loop)) begin
            fsm_st      <= ST_IDLE;
            busy        <= 1'b0;
            done        <= !stop;
            cur_idx     <= '0;
            dwell_cnt   <= '0;
            state       <= WAVE_OFF;
            state_freq  <= '0;
            state_amp   <= '0;
            state_phase <= '0;
          end else if (tick) begin
            if (!end_of_entry) begin
              dwell_cnt <= dwell_cnt - DWELL_W'(1);
            end else begin
              cur_idx     <= rd_addr;
              dwell_cnt   <= ld_dwell;
              state       <= rd_data[DWELL_W+WAVE_OFS  +: WAVE_W];
              state_freq  <= rd_data[DWELL_W+FREQ_OFS  +: FREQ_W];
              state_amp   <= rd_data[DWELL_W+AMP_OFS   +: AMP_W];
              state_phase <= rd_data[DWELL_W+PHASE_OFS +: PHASE_W];
            end
          end
        end
        default: fsm_st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_awg_seq_ctrl.sv
// Directed bench for awg_seq_ctrl: one-shot, looping, rewrite-while-playing, stop and reset cases.
module tb_awg_seq_ctrl;

  localparam int IDX_W   = 3;
  localparam int DWELL_W = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                tick = 1'b0;
  logic                start = 1'b0;
  logic                stop = 1'b0;
  logic                loop = 1'b0;
  logic [IDX_W-1:0]    last_idx = '0;
  logic                wr_en = 1'b0;
  logic [IDX_W-1:0]    wr_addr = '0;
  logic [26+DWELL_W-1:0] wr_data = '0;
  logic [2:0]          state;
  logic [11:0]         state_freq;
  logic [2:0]          state_amp;
  logic [7:0]          state_phase;
  logic [IDX_W-1:0]    cur_idx;
  logic                busy;
  logic                done;

  int n_checks = 0;
  int n_errors = 0;

  awg_seq_ctrl #(.IDX_W(IDX_W), .DWELL_W(DWELL_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .start       (start),
    .stop        (stop),
    .loop        (loop),
    .last_idx    (last_idx),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .state       (state),
    .state_freq  (state_freq),
    .state_amp   (state_amp),
    .state_phase (state_phase),
    .cur_idx     (cur_idx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic wr(input int addr, input int wave, input int freq, input int amp,
                    input int phase, input int dwell);
    wr_en   = 1'b1;
    wr_addr = IDX_W'(addr);
    wr_data = {3'(wave), 12'(freq), 3'(amp), 8'(phase), 16'(dwell)};
    step();
    wr_en   = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int wave, input int freq, input int amp,
                            input int phase, input int idx, input int bsy, input int dn);
    check({tag, ".wave"},  32'(state),       32'(wave));
    check({tag, ".freq"},  32'(state_freq),  32'(freq));
    check({tag, ".amp"},   32'(state_amp),   32'(amp));
    check({tag, ".phase"}, 32'(state_phase), 32'(phase));
    check({tag, ".idx"},   32'(cur_idx),     32'(idx));
    check({tag, ".busy"},  32'(busy),        32'(bsy));
    check({tag, ".done"},  32'(done),        32'(dn));
  endtask

  initial begin
    step();
    step();
    expect_out("reset", 7, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();

    wr(0, 0, 100, 3, 0, 2);
    wr(1, 3, 200, 1, 45, 3);
    wr(2, 1, 50, 7, 90, 1);
    last_idx = 3'd2;
    loop = 1'b0;
    expect_out("idle_after_wr", 7, 0, 0, 0, 0, 0, 0);

    // One-shot pass: SAW x2, SIN x3, TRI x1, then done.
    start = 1'b1; step(); start = 1'b0;
    expect_out("os_start", 0, 100, 3, 0, 0, 1, 0);
    do_tick(); expect_out("os_t1", 0, 100, 3, 0, 0, 1, 0);
    do_tick(); expect_out("os_t2", 3, 200, 1, 45, 1, 1, 0);
    step();    expect_out("os_hold", 3, 200, 1, 45, 1, 1, 0);
    do_tick(); expect_out("os_t3", 3, 200, 1, 45, 1, 1, 0);
    do_tick(); expect_out("os_t4", 3, 200, 1, 45, 1, 1, 0);
    do_tick(); expect_out("os_t5", 1, 50, 7, 90, 2, 1, 0);
    do_tick(); expect_out("os_t6", 7, 0, 0, 0, 0, 0, 1);
    step();    expect_out("os_after", 7, 0, 0, 0, 0, 0, 0);

    // Looping pass with a rewrite of entry 1 while it plays.
    loop = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    expect_out("lp_start", 0, 100, 3, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) do_tick();
    expect_out("lp_t5", 1, 50, 7, 90, 2, 1, 0);
    do_tick(); expect_out("lp_t6_wrap", 0, 100, 3, 0, 0, 1, 0);
    do_tick();
    do_tick(); expect_out("lp_t8", 3, 200, 1, 45, 1, 1, 0);
    wr(1, 2, 300, 2, 10, 0);
    expect_out("lp_rewrite_held", 3, 200, 1, 45, 1, 1, 0);
    do_tick(); do_tick();
    expect_out("lp_t10_old_dwell", 3, 200, 1, 45, 1, 1, 0);
    do_tick(); expect_out("lp_t11", 1, 50, 7, 90, 2, 1, 0);
    do_tick(); expect_out("lp_t12_wrap", 0, 100, 3, 0, 0, 1, 0);
    do_tick();
    do_tick(); expect_out("lp_t14_new", 2, 300, 2, 10, 1, 1, 0);
    do_tick(); expect_out("lp_t15_dwell0", 1, 50, 7, 90, 2, 1, 0);

    // start while running is ignored.
    start = 1'b1; step(); step(); start = 1'b0;
    expect_out("run_start_ign", 1, 50, 7, 90, 2, 1, 0);

    // stop together with the final tick of the entry: abort, no advance, no done.
    stop = 1'b1; tick = 1'b1; step(); stop = 1'b0; tick = 1'b0;
    expect_out("stop_tick", 7, 0, 0, 0, 0, 0, 0);
    step(); expect_out("stop_no_done", 7, 0, 0, 0, 0, 0, 0);

    // start and stop together in IDLE: stays idle.
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    expect_out("start_stop_idle", 7, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-run clears outputs before the next clock edge.
    start = 1'b1; step(); start = 1'b0;
    expect_out("ar_run", 0, 100, 3, 0, 0, 1, 0);
    #2 rst = 1'b1;
    #1 expect_out("ar_async", 7, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    step(); expect_out("ar_after", 7, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
